uart_tx_fifo_baud: RTL

Parametrised next-generation UART transmitter. Adds an input FIFO with a valid/ready handshake, a runtime baud divisor, and selectable 1 or 2 stop bits on top of the existing LSB-first framing with optional even/odd parity. It sits between the bus-side producer and the serial pin. Back-to-back words leave as continuous frames with no idle gap.

---
 rtl/uart_tx_fifo_baud.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_baud.sv
// uart_tx_fifo_baud: UART transmitter with input FIFO, runtime baud divisor, optional parity and 1/2 stop bits
module uart_tx_fifo_baud #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DIV_WIDTH-1:0]               baud_div,
  input  logic                               parity_enable,
  input  logic                               parity_type,
  input  logic                               stop_bits,
  input  logic                               data_valid,
  input  logic [DATA_WIDTH-1:0]              parallel_data,
  output logic                               data_ready,
  output logic                               serial_data_out,
  output logic                               busy,
  output logic                               fifo_full,
  output logic                               fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic pen_q, pen_d, par_q, par_d, stop2_q, stop2_d, line_q, line_d;
  logic push, pop, tick, last_stop;
  assign fifo_full = count_q == CW'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign data_ready = !fifo_full;
  assign fifo_count = count_q;
  assign busy = state_q != IDLE || !fifo_empty;
  assign serial_data_out = line_q;
  assign push = data_valid && !fifo_full;
  assign tick = state_q != IDLE && cnt_q == div_q - DIV_WIDTH'(1);
  assign last_stop = bit_q == BW'(stop2_q);
  assign pop = !fifo_empty && (state_q == IDLE || (state_q == STOP && tick && last_stop));
  // state and datapath registers; reset aborts any frame and forces the line high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      div_q    <= DIV_WIDTH'(1);
      bit_q    <= '0;
      shift_q  <= '0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      line_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pen_q    <= pen_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      line_q   <= line_d;
    end
  end
  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= parallel_data;
  end
  // frame sequencing; STOP chains straight into START when another word is queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fifo_empty ? IDLE : START;
      START:   state_d = tick ? DATA : START;
      DATA:    state_d = tick && bit_q == BW'(DATA_WIDTH-1) ? (pen_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = tick && last_stop ? (fifo_empty ? IDLE : START) : STOP;
      default: state_d = IDLE;
    endcase
  end
  // FIFO bookkeeping, bit timing, and per-frame config latched at pop
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = state_q == IDLE || tick ? '0 : cnt_q + DIV_WIDTH'(1);
    bit_d    = state_d != state_q ? '0 : tick ? bit_q + BW'(1) : bit_q;
    shift_d  = pop ? mem[rd_ptr_q] : state_q == DATA && tick ? shift_q >> 1 : shift_q;
    div_d    = pop ? (baud_div == '0 ? DIV_WIDTH'(1) : baud_div) : div_q;
    pen_d    = pop ? parity_enable : pen_q;
    par_d    = pop ? ^mem[rd_ptr_q] ^ parity_type : par_q;
    stop2_d  = pop ? stop_bits : stop2_q;
  end
  // line level for the coming state, registered so the pin never glitches
  always_comb begin
    line_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
endmodule
